// File: rtl/spi_rx_pkg.sv
// Shared types and helpers for the SPI frame receiver.
package spi_rx_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int unsigned SYNC_STAGES = 2;

  // Ceiling log2, used to size pointers and counters at elaboration.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Holding buffer between the deserialiser and the output stream.
// SPI_RX_FIFO_EN defined: FIFO_DEPTH-entry circular FIFO; otherwise a single register.
module spi_rx_fifo
  import spi_rx_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] dout
);

`ifdef SPI_RX_FIFO_EN
  localparam int unsigned AW = clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              wr_en;
  logic              rd_en;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer and storage update; storage cleared so dout reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
`else
  logic [DATA_W-1:0] hold_q;
  logic              valid_q;
  logic              unused_depth;

  // Depth parameter has no effect in the single-register build.
  assign unused_depth = (FIFO_DEPTH > 1);

  assign full  = valid_q;
  assign empty = !valid_q;
  assign dout  = hold_q;

  // Single-entry hold; a pop frees the slot for a same-cycle push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else if (push && (!valid_q || pop)) begin
      hold_q  <= din;
      valid_q <= 1'b1;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/spi_frame_receiver.sv
// Peripheral-side SPI mode-0 receiver: oversampled pins, MSB-first words,
// valid/ready output behind a holding buffer.
// Build option: SPI_RX_FIFO_EN selects a FIFO_DEPTH-entry FIFO instead of one register.
module spi_frame_receiver
  import spi_rx_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clock,
  input  logic              spi_data,
  input  logic              cs_n,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              frame_done,
  output logic              frag_err,
  output logic              overrun,
  input  logic              clr_err
);

  localparam int unsigned CNT_W = clog2(DATA_W + 1);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sck_d;
  logic                   sck_rise_c;
  logic                   data_s;
  logic                   cs_s;

  state_t                 state;
  logic [DATA_W-1:0]      shift_reg;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   push_q;

  logic                   buf_full;
  logic                   buf_empty;

  // Pin synchronisers plus the extra SCK stage for rise detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      data_sync <= '0;
      cs_sync   <= '1;
      sck_d     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clock};
      data_sync <= {data_sync[SYNC_STAGES-2:0], spi_data};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sck_d     <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign sck_rise_c = sck_sync[SYNC_STAGES-1] && !sck_d;
  assign data_s     = data_sync[SYNC_STAGES-1];
  assign cs_s       = cs_sync[SYNC_STAGES-1];

  // Frame FSM with deserialiser; a cs_n release takes priority over a coincident SCK rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      push_q     <= 1'b0;
      frame_done <= 1'b0;
      frag_err   <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      frame_done <= 1'b0;
      frag_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (!cs_s) begin
            state     <= ACTIVE;
            shift_reg <= '0;
            bit_cnt   <= '0;
          end
        end
        ACTIVE: begin
          if (cs_s) begin
            state      <= IDLE;
            frame_done <= 1'b1;
            frag_err   <= (bit_cnt != '0);
          end else if (sck_rise_c) begin
            shift_reg <= {shift_reg[DATA_W-2:0], data_s};
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              bit_cnt <= '0;
              push_q  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completed word is pushed the cycle after its last bit lands in shift_reg.
  spi_rx_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push_q),
    .din  (shift_reg),
    .pop  (m_ready),
    .full (buf_full),
    .empty(buf_empty),
    .dout (m_data)
  );

  assign m_valid = !buf_empty;

  // Sticky drop flag; clear wins over a same-cycle drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (clr_err) begin
      overrun <= 1'b0;
    end else if (push_q && buf_full && !(m_ready && !buf_empty)) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed bench for spi_frame_receiver with a word-queue reference model.
module tb_spi_frame_receiver;

`ifdef SPI_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_clock = 1'b0;
  logic       spi_data = 1'b0;
  logic       cs_n = 1'b1;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic       frame_done;
  logic       frag_err;
  logic       overrun;
  logic       clr_err = 1'b0;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  int         rx_cnt = 0;
  int         fd_cnt = 0;
  int         fe_cnt = 0;
  logic       fd_prev = 1'b0;
  logic [7:0] last_rx = 8'h00;
  int         rx_base, fd_base, fe_base;

  spi_frame_receiver #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_clock (spi_clock),
    .spi_data  (spi_data),
    .cs_n      (cs_n),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .frame_done(frame_done),
    .frag_err  (frag_err),
    .overrun   (overrun),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 ns after a rising edge, so they are stable at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a finished word enters the buffer if there is room, otherwise it is lost.
  task automatic model_push(input logic [7:0] w);
    if (exp_q.size() < CAP) exp_q.push_back(w);
  endtask

  // Send the top nbits of b MSB-first at an 8-clk SCK period.
  task automatic send_byte(input logic [7:0] b, input int nbits, input bit lat);
    for (int i = 0; i < nbits; i++) begin
      spi_data = b[7-i];
      repeat (4) tick();
      spi_clock = 1'b1;
      if (i == 7) model_push(b);
      if (lat && i == 7) begin
        repeat (3) tick();
        check("latency_3clk_low", {31'd0, m_valid}, 32'd0);
        tick();
        check("latency_4clk_high", {31'd0, m_valid}, 32'd1);
      end else begin
        repeat (4) tick();
      end
      spi_clock = 1'b0;
    end
  endtask

  task automatic cs_start();
    cs_n = 1'b0;
    repeat (4) tick();
  endtask

  task automatic cs_end();
    repeat (4) tick();
    cs_n = 1'b1;
    repeat (10) tick();
  endtask

  task automatic mark();
    rx_base = rx_cnt;
    fd_base = fd_cnt;
    fe_base = fe_cnt;
  endtask

  // Per-cycle compare of the stream and pulse outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {31'd0, m_valid}, 32'd0);
        end else begin
          check("m_data", {24'd0, m_data}, {24'd0, exp_q[0]});
          if (m_ready) begin
            last_rx = m_data;
            rx_cnt++;
            void'(exp_q.pop_front());
          end
        end
      end
      if (frame_done) begin
        fd_cnt++;
        check("frame_done_one_cycle", {31'd0, fd_prev}, 32'd0);
      end
      if (frag_err) begin
        fe_cnt++;
        check("frag_err_with_done", {31'd0, frame_done}, 32'd1);
      end
      fd_prev = frame_done;
    end else begin
      fd_prev = 1'b0;
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state, SCK noise with cs_n high
    repeat (3) tick();
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", {24'd0, m_data}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_frag_err", {31'd0, frag_err}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      spi_clock = ~spi_clock;
      repeat (2) tick();
    end
    spi_clock = 1'b0;
    repeat (4) tick();
    check("idle_no_valid", {31'd0, m_valid}, 32'd0);
    check("idle_no_frame_done", fd_cnt, 32'd0);

    // 2: single byte with latency check
    mark();
    cs_start();
    send_byte(8'hA5, 8, 1'b1);
    cs_end();
    check("t2_words", rx_cnt - rx_base, 32'd1);
    check("t2_data_literal", {24'd0, last_rx}, 32'hA5);
    check("t2_frame_done", fd_cnt - fd_base, 32'd1);
    check("t2_frag_err", fe_cnt - fe_base, 32'd0);
    check("t2_overrun", {31'd0, overrun}, 32'd0);

    // 3: two back-to-back bytes in one frame
    mark();
    cs_start();
    send_byte(8'h3C, 8, 1'b0);
    send_byte(8'hC3, 8, 1'b0);
    cs_end();
    check("t3_words", rx_cnt - rx_base, 32'd2);
    check("t3_last_literal", {24'd0, last_rx}, 32'hC3);
    check("t3_frame_done", fd_cnt - fd_base, 32'd1);
    check("t3_model_drained", exp_q.size(), 32'd0);

    // 4: 5-bit fragment, then a clean byte
    mark();
    cs_start();
    send_byte(8'hB8, 5, 1'b0);
    cs_end();
    check("t4_frag_words", rx_cnt - rx_base, 32'd0);
    check("t4_frag_done", fd_cnt - fd_base, 32'd1);
    check("t4_frag_err", fe_cnt - fe_base, 32'd1);
    mark();
    cs_start();
    send_byte(8'h81, 8, 1'b0);
    cs_end();
    check("t4_next_words", rx_cnt - rx_base, 32'd1);
    check("t4_next_literal", {24'd0, last_rx}, 32'h81);
    check("t4_next_frag_err", fe_cnt - fe_base, 32'd0);

    // 5: overrun with the consumer stalled
    m_ready = 1'b0;
    mark();
    cs_start();
`ifdef SPI_RX_FIFO_EN
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 8, 1'b0);
`else
    send_byte(8'h11, 8, 1'b0);
    send_byte(8'h22, 8, 1'b0);
`endif
    cs_end();
    check("t5_overrun_set", {31'd0, overrun}, 32'd1);
    check("t5_valid_held", {31'd0, m_valid}, 32'd1);
`ifdef SPI_RX_FIFO_EN
    check("t5_head_literal", {24'd0, m_data}, 32'h01);
`else
    check("t5_head_literal", {24'd0, m_data}, 32'h11);
`endif
    m_ready = 1'b1;
    repeat (10) tick();
    check("t5_drained_words", rx_cnt - rx_base, CAP);
    check("t5_valid_after_drain", {31'd0, m_valid}, 32'd0);
`ifdef SPI_RX_FIFO_EN
    check("t5_last_literal", {24'd0, last_rx}, 32'h04);
`else
    check("t5_last_literal", {24'd0, last_rx}, 32'h11);
`endif
    check("t5_overrun_sticky", {31'd0, overrun}, 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tick();
    check("t5_overrun_cleared", {31'd0, overrun}, 32'd0);

    // 6: reset mid-frame, then a fresh frame
    mark();
    cs_start();
    send_byte(8'hF0, 4, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, m_valid}, 32'd0);
    check("t6_rst_data", {24'd0, m_data}, 32'd0);
    check("t6_rst_done", {31'd0, frame_done}, 32'd0);
    check("t6_rst_frag", {31'd0, frag_err}, 32'd0);
    check("t6_rst_overrun", {31'd0, overrun}, 32'd0);
    exp_q.delete();
    repeat (3) tick();
    cs_n = 1'b1;
    rst_n = 1'b1;
    repeat (6) tick();
    check("t6_no_pulse_after_rst", fd_cnt - fd_base, 32'd0);
    mark();
    cs_start();
    send_byte(8'h5A, 8, 1'b0);
    cs_end();
    check("t6_words", rx_cnt - rx_base, 32'd1);
    check("t6_data_literal", {24'd0, last_rx}, 32'h5A);
    check("t6_frag_err", fe_cnt - fe_base, 32'd0);
    check("t6_frame_done", fd_cnt - fd_base, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
